// File: rtl/l2_axi_pkg.sv
// ============================================================================
// Module   : l2_axi_pkg
// Purpose  : Shared definitions for the L2-to-AXI4 memory bridge: bridge
//            state encoding, AXI burst constants and the line-alignment helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package l2_axi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AR   = 3'd1,
        ST_R    = 3'd2,
        ST_AW   = 3'd3,
        ST_W    = 3'd4,
        ST_B    = 3'd5,
        ST_DONE = 3'd6
    } state_e;

    localparam logic [1:0] c_burst_incr = 2'b01;
    localparam logic [2:0] c_size_word  = 3'b010;

    // Clear the word offset and byte offset so the burst starts on a line.
    function automatic logic [31:0] line_align(input logic [31:0] addr,
                                               input int          offset_width);
        logic [31:0] mask;
        mask = ~((32'd1 << (offset_width + 2)) - 32'd1);
        return addr & mask;
    endfunction

endpackage

`default_nettype wire

// File: rtl/l2_mem_axi_bridge_line_beat_buffer.sv
// ============================================================================
// Module   : line_beat_buffer
// Purpose  : One cache line held as 2^OFFSET_WIDTH 32-bit words. Offers a
//            word-wide write port for assembling read bursts, a full-line
//            load for write bursts, and a word read mux for disassembly.
// Ports    : clk, rst        - clock, async active-high reset (clears line)
//            load/load_line  - capture a whole line (takes priority)
//            wr_en/wr_idx/wr_word - write one word
//            wr_first        - with wr_en, zero every word not being written
//            rd_idx/rd_word  - word read mux
//            line            - full registered line
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module line_beat_buffer #(
    parameter int OFFSET_WIDTH = 3
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            load,
    input  logic [(32<<OFFSET_WIDTH)-1:0]   load_line,
    input  logic                            wr_en,
    input  logic                            wr_first,
    input  logic [OFFSET_WIDTH-1:0]         wr_idx,
    input  logic [31:0]                     wr_word,
    input  logic [OFFSET_WIDTH-1:0]         rd_idx,
    output logic [31:0]                     rd_word,
    output logic [(32<<OFFSET_WIDTH)-1:0]   line
);

    localparam int WORDS = 1 << OFFSET_WIDTH;

    logic [31:0] r_words [WORDS];

    for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
        // The first beat of a new burst wipes stale words, so a single-beat
        // access leaves the upper part of the line at zero.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_words[gi] <= '0;
            end else if (load) begin
                r_words[gi] <= load_line[gi*32 +: 32];
            end else if (wr_en && (wr_idx == OFFSET_WIDTH'(gi))) begin
                r_words[gi] <= wr_word;
            end else if (wr_en && wr_first) begin
                r_words[gi] <= '0;
            end
        end

        assign line[gi*32 +: 32] = r_words[gi];
    end

    assign rd_word = r_words[rd_idx];

endmodule

`default_nettype wire

// File: rtl/l2_mem_axi_bridge.sv
// ============================================================================
// Module   : l2_mem_axi_bridge
// Purpose  : Turns L2 memory-side requests into AXI4 transactions, one at a
//            time. Cached accesses become full-line INCR bursts, uncached
//            (SUC) accesses single beats. Read beats are assembled into a
//            line returned on din_mem_l2cache.
// Ports    : clk, rst                      - clock, async active-high reset
//            L2 side : addr_*, dout, req_r/w, SUC, wstrb, size, rdy (in)
//                      addrOK_r/w, din, dataOK (out)
//            AXI side: AR/R/AW/W/B channels (no rresp/bresp)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module l2_mem_axi_bridge
    import l2_axi_pkg::*;
#(
    parameter int OFFSET_WIDTH = 3
) (
    input  logic                            clk,
    input  logic                            rst,
    // L2 side
    input  logic [31:0]                     addr_l2cache_mem_r,
    input  logic [31:0]                     addr_l2cache_mem_w,
    input  logic [(32<<OFFSET_WIDTH)-1:0]   dout_l2cache_mem,
    input  logic                            l2cache_mem_req_r,
    input  logic                            l2cache_mem_req_w,
    input  logic                            l2cache_mem_SUC,
    input  logic [3:0]                      l2cache_mem_wstrb,
    input  logic [1:0]                      l2cache_mem_size,
    input  logic                            l2cache_mem_rdy,
    output logic                            mem_l2cache_addrOK_r,
    output logic                            mem_l2cache_addrOK_w,
    output logic [(32<<OFFSET_WIDTH)-1:0]   din_mem_l2cache,
    output logic                            mem_l2cache_dataOK,
    // AXI read address / data
    output logic [31:0]                     araddr,
    output logic [7:0]                      arlen,
    output logic [2:0]                      arsize,
    output logic [1:0]                      arburst,
    output logic                            arvalid,
    input  logic                            arready,
    input  logic [31:0]                     rdata,
    input  logic                            rlast,
    input  logic                            rvalid,
    output logic                            rready,
    // AXI write address / data / response
    output logic [31:0]                     awaddr,
    output logic [7:0]                      awlen,
    output logic [2:0]                      awsize,
    output logic [1:0]                      awburst,
    output logic                            awvalid,
    input  logic                            awready,
    output logic [31:0]                     wdata,
    output logic [3:0]                      wstrb,
    output logic                            wlast,
    output logic                            wvalid,
    input  logic                            wready,
    input  logic                            bvalid,
    output logic                            bready
);

    localparam int         WORDS       = 1 << OFFSET_WIDTH;
    localparam logic [7:0] c_full_len  = 8'(WORDS - 1);
    localparam logic [7:0] c_words     = 8'(WORDS);

    state_e                  r_state;
    logic [7:0]              r_cnt;
    logic                    r_suc;

    logic                    w_rbuf_wr_en;
    logic [OFFSET_WIDTH-1:0] w_wbuf_idx;
    logic [31:0]             w_wbuf_word;
    logic [31:0]             w_rbuf_word_unused;
    logic [(32<<OFFSET_WIDTH)-1:0] w_wbuf_line_unused;

    // Beats past the end of the line are dropped; an uncached read only
    // ever keeps its first word.
    assign w_rbuf_wr_en = (r_state == ST_R) && rvalid && (r_cnt < c_words)
                          && (!r_suc || (r_cnt == 8'd0));

    // wdata is registered, so the mux looks one beat ahead of r_cnt.
    assign w_wbuf_idx = (r_state == ST_W) ? OFFSET_WIDTH'(r_cnt + 8'd1)
                                          : '0;

    line_beat_buffer #(.OFFSET_WIDTH(OFFSET_WIDTH)) u_rd_buf (
        .clk       (clk),
        .rst       (rst),
        .load      (1'b0),
        .load_line ('0),
        .wr_en     (w_rbuf_wr_en),
        .wr_first  (r_cnt == 8'd0),
        .wr_idx    (r_cnt[OFFSET_WIDTH-1:0]),
        .wr_word   (rdata),
        .rd_idx    ('0),
        .rd_word   (w_rbuf_word_unused),
        .line      (din_mem_l2cache)
    );

    line_beat_buffer #(.OFFSET_WIDTH(OFFSET_WIDTH)) u_wr_buf (
        .clk       (clk),
        .rst       (rst),
        .load      ((r_state == ST_IDLE) && l2cache_mem_req_w),
        .load_line (dout_l2cache_mem),
        .wr_en     (1'b0),
        .wr_first  (1'b0),
        .wr_idx    ('0),
        .wr_word   ('0),
        .rd_idx    (w_wbuf_idx),
        .rd_word   (w_wbuf_word),
        .line      (w_wbuf_line_unused)
    );

    assign arburst = c_burst_incr;
    assign awburst = c_burst_incr;
    assign rready  = (r_state == ST_R);
    assign bready  = (r_state == ST_B);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state              <= ST_IDLE;
            r_cnt                <= '0;
            r_suc                <= 1'b0;
            mem_l2cache_addrOK_r <= 1'b0;
            mem_l2cache_addrOK_w <= 1'b0;
            mem_l2cache_dataOK   <= 1'b0;
            araddr               <= '0;
            arlen                <= '0;
            arsize               <= '0;
            arvalid              <= 1'b0;
            awaddr               <= '0;
            awlen                <= '0;
            awsize               <= '0;
            awvalid              <= 1'b0;
            wdata                <= '0;
            wstrb                <= '0;
            wlast                <= 1'b0;
            wvalid               <= 1'b0;
        end else begin
            mem_l2cache_addrOK_r <= 1'b0;
            mem_l2cache_addrOK_w <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // Write first so a dirty victim leaves before its refill.
                    if (l2cache_mem_req_w) begin
                        mem_l2cache_addrOK_w <= 1'b1;
                        r_suc   <= l2cache_mem_SUC;
                        awaddr  <= l2cache_mem_SUC ? addr_l2cache_mem_w
                                   : line_align(addr_l2cache_mem_w, OFFSET_WIDTH);
                        awlen   <= l2cache_mem_SUC ? 8'd0 : c_full_len;
                        awsize  <= l2cache_mem_SUC ? {1'b0, l2cache_mem_size}
                                                   : c_size_word;
                        wstrb   <= l2cache_mem_SUC ? l2cache_mem_wstrb : 4'hF;
                        r_state <= ST_AW;
                    end else if (l2cache_mem_req_r) begin
                        mem_l2cache_addrOK_r <= 1'b1;
                        r_suc   <= l2cache_mem_SUC;
                        araddr  <= l2cache_mem_SUC ? addr_l2cache_mem_r
                                   : line_align(addr_l2cache_mem_r, OFFSET_WIDTH);
                        arlen   <= l2cache_mem_SUC ? 8'd0 : c_full_len;
                        arsize  <= l2cache_mem_SUC ? {1'b0, l2cache_mem_size}
                                                   : c_size_word;
                        r_state <= ST_AR;
                    end
                end
                ST_AR: begin
                    if (!arvalid) begin
                        arvalid <= 1'b1;
                    end else if (arready) begin
                        arvalid <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= ST_R;
                    end
                end
                ST_R: begin
                    if (rvalid) begin
                        if (r_cnt < c_words) begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                        if (rlast) begin
                            mem_l2cache_dataOK <= 1'b1;
                            r_state            <= ST_DONE;
                        end
                    end
                end
                ST_AW: begin
                    if (!awvalid) begin
                        awvalid <= 1'b1;
                    end else if (awready) begin
                        awvalid <= 1'b0;
                        wvalid  <= 1'b1;
                        wdata   <= w_wbuf_word;
                        wlast   <= (awlen == 8'd0);
                        r_cnt   <= '0;
                        r_state <= ST_W;
                    end
                end
                ST_W: begin
                    if (wready) begin
                        if (wlast) begin
                            wvalid  <= 1'b0;
                            wlast   <= 1'b0;
                            r_state <= ST_B;
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                            wdata <= w_wbuf_word;
                            wlast <= ((r_cnt + 8'd1) == awlen);
                        end
                    end
                end
                ST_B: begin
                    if (bvalid) begin
                        mem_l2cache_dataOK <= 1'b1;
                        r_state            <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (l2cache_mem_rdy) begin
                        mem_l2cache_dataOK <= 1'b0;
                        r_state            <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_l2_mem_axi_bridge.sv
// ============================================================================
// Module   : tb_l2_mem_axi_bridge
// Purpose  : Directed self-checking bench for l2_mem_axi_bridge
//            (OFFSET_WIDTH = 3, 256-bit lines) with a hand-driven AXI slave.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_l2_mem_axi_bridge;

    logic         clk;
    logic         rst;
    logic [31:0]  addr_l2cache_mem_r, addr_l2cache_mem_w;
    logic [255:0] dout_l2cache_mem;
    logic         l2cache_mem_req_r, l2cache_mem_req_w, l2cache_mem_SUC;
    logic [3:0]   l2cache_mem_wstrb;
    logic [1:0]   l2cache_mem_size;
    logic         l2cache_mem_rdy;
    logic         mem_l2cache_addrOK_r, mem_l2cache_addrOK_w;
    logic [255:0] din_mem_l2cache;
    logic         mem_l2cache_dataOK;
    logic [31:0]  araddr, awaddr, rdata, wdata;
    logic [7:0]   arlen, awlen;
    logic [2:0]   arsize, awsize;
    logic [1:0]   arburst, awburst;
    logic         arvalid, arready, rlast, rvalid, rready;
    logic         awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic [3:0]   wstrb;

    int n_vec  = 0;
    int n_miss = 0;

    logic [130:0] ctl_bus;
    assign ctl_bus = {mem_l2cache_addrOK_r, mem_l2cache_addrOK_w, mem_l2cache_dataOK,
                      arvalid, awvalid, wvalid, wlast, rready, bready,
                      araddr, awaddr, arlen, awlen, arsize, awsize, wdata, wstrb};

    l2_mem_axi_bridge #(.OFFSET_WIDTH(3)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .addr_l2cache_mem_r   (addr_l2cache_mem_r),
        .addr_l2cache_mem_w   (addr_l2cache_mem_w),
        .dout_l2cache_mem     (dout_l2cache_mem),
        .l2cache_mem_req_r    (l2cache_mem_req_r),
        .l2cache_mem_req_w    (l2cache_mem_req_w),
        .l2cache_mem_SUC      (l2cache_mem_SUC),
        .l2cache_mem_wstrb    (l2cache_mem_wstrb),
        .l2cache_mem_size     (l2cache_mem_size),
        .l2cache_mem_rdy      (l2cache_mem_rdy),
        .mem_l2cache_addrOK_r (mem_l2cache_addrOK_r),
        .mem_l2cache_addrOK_w (mem_l2cache_addrOK_w),
        .din_mem_l2cache      (din_mem_l2cache),
        .mem_l2cache_dataOK   (mem_l2cache_dataOK),
        .araddr               (araddr),
        .arlen                (arlen),
        .arsize               (arsize),
        .arburst              (arburst),
        .arvalid              (arvalid),
        .arready              (arready),
        .rdata                (rdata),
        .rlast                (rlast),
        .rvalid               (rvalid),
        .rready               (rready),
        .awaddr               (awaddr),
        .awlen                (awlen),
        .awsize               (awsize),
        .awburst              (awburst),
        .awvalid              (awvalid),
        .awready              (awready),
        .wdata                (wdata),
        .wstrb                (wstrb),
        .wlast                (wlast),
        .wvalid               (wvalid),
        .wready               (wready),
        .bvalid               (bvalid),
        .bready               (bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] make_line(input logic [31:0] base);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = base + 32'(i);
        return l;
    endfunction

    task automatic read_req(input logic [31:0] a, input logic suc, input logic [1:0] sz);
        addr_l2cache_mem_r = a;
        l2cache_mem_SUC    = suc;
        l2cache_mem_size   = sz;
        l2cache_mem_req_r  = 1'b1;
        @(negedge clk);
        chk("addrok_r", mem_l2cache_addrOK_r, 1'b1);
        l2cache_mem_req_r = 1'b0;
        l2cache_mem_SUC   = 1'b0;
        @(negedge clk);
        chk("arvalid_rise", arvalid, 1'b1);
    endtask

    task automatic ar_phase(input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz);
        chk("ar_fields", {araddr, arlen, arsize, arburst}, {a, len, sz, 2'b01});
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        chk("ar_drop_rready", {arvalid, rready}, 2'b01);
    endtask

    task automatic r_beat(input logic [31:0] d, input logic last, input int gap);
        repeat (gap) @(negedge clk);
        rdata  = d;
        rlast  = last;
        rvalid = 1'b1;
        @(negedge clk);
        rvalid = 1'b0;
        rlast  = 1'b0;
    endtask

    task automatic write_req(input logic [31:0] a, input logic [255:0] line);
        addr_l2cache_mem_w = a;
        dout_l2cache_mem   = line;
        l2cache_mem_wstrb  = 4'h3;   // ignored for cached writes
        l2cache_mem_req_w  = 1'b1;
        @(negedge clk);
        chk("addrok_w", mem_l2cache_addrOK_w, 1'b1);
        l2cache_mem_req_w = 1'b0;
        @(negedge clk);
        chk("awvalid_rise", awvalid, 1'b1);
    endtask

    task automatic aw_phase(input logic [31:0] a, input int delay);
        chk("aw_fields", {awaddr, awlen, awsize, awburst}, {a, 8'd7, 3'd2, 2'b01});
        for (int k = 0; k < delay; k++) begin
            @(negedge clk);
            chk("aw_hold_no_w", {awvalid, wvalid}, 2'b10);
        end
        awready = 1'b1;
        @(negedge clk);
        awready = 1'b0;
    endtask

    task automatic w_beats(input logic [255:0] line);
        wready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 20 && !wvalid; k++) @(negedge clk);
            chk("w_beat", {wvalid, wdata, wstrb, wlast},
                {1'b1, line[i*32 +: 32], 4'hF, (i == 7)});
            @(negedge clk);
        end
        wready = 1'b0;
        chk("w_end_bready", {wvalid, bready}, 2'b01);
        bvalid = 1'b1;
        @(negedge clk);
        bvalid = 1'b0;
        chk("b_done", mem_l2cache_dataOK, 1'b1);
    endtask

    task automatic release_done();
        l2cache_mem_rdy = 1'b1;
        @(negedge clk);
        l2cache_mem_rdy = 1'b0;
        chk("done_clr", mem_l2cache_dataOK, 1'b0);
    endtask

    initial begin
        logic [255:0] exp_line;
        logic         seen_ok;

        rst = 1'b1;
        addr_l2cache_mem_r = '0; addr_l2cache_mem_w = '0; dout_l2cache_mem = '0;
        l2cache_mem_req_r = 1'b0; l2cache_mem_req_w = 1'b0; l2cache_mem_SUC = 1'b0;
        l2cache_mem_wstrb = '0; l2cache_mem_size = '0; l2cache_mem_rdy = 1'b0;
        arready = 1'b0; rdata = '0; rlast = 1'b0; rvalid = 1'b0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_din", din_mem_l2cache, '0);
        chk("rst_ctl", ctl_bus, '0);
        rst = 1'b0;
        @(negedge clk);

        // Cached read, unaligned address
        read_req(32'h1C00_0014, 1'b0, 2'd0);
        ar_phase(32'h1C00_0000, 8'd7, 3'd2);
        for (int i = 0; i < 8; i++) r_beat(32'(i), (i == 7), 0);
        chk("rd_latency", mem_l2cache_dataOK, 1'b1);
        chk("rd_line", din_mem_l2cache, make_line(32'h0));
        repeat (2) @(negedge clk);
        chk("rd_hold", {mem_l2cache_dataOK, din_mem_l2cache}, {1'b1, make_line(32'h0)});
        release_done();

        // SUC byte read
        read_req(32'hBFD0_0003, 1'b1, 2'd0);
        ar_phase(32'hBFD0_0003, 8'd0, 3'd0);
        r_beat(32'h55, 1'b1, 1);
        chk("suc_line", {mem_l2cache_dataOK, din_mem_l2cache}, {1'b1, 256'h55});
        release_done();

        // Cached writeback with delayed awready
        write_req(32'h0000_2040, make_line(32'hA0));
        aw_phase(32'h0000_2040, 3);
        w_beats(make_line(32'hA0));
        chk("din_kept", din_mem_l2cache, 256'h55);
        release_done();

        // Simultaneous read and write requests
        addr_l2cache_mem_w = 32'h0000_0100;
        dout_l2cache_mem   = make_line(32'hB0);
        addr_l2cache_mem_r = 32'h0000_1008;
        l2cache_mem_req_w  = 1'b1;
        l2cache_mem_req_r  = 1'b1;
        @(negedge clk);
        chk("both_addrok", {mem_l2cache_addrOK_w, mem_l2cache_addrOK_r}, 2'b10);
        l2cache_mem_req_w = 1'b0;
        @(negedge clk);
        aw_phase(32'h0000_0100, 0);
        w_beats(make_line(32'hB0));
        release_done();
        chk("no_early_rd", mem_l2cache_addrOK_r, 1'b0);
        @(negedge clk);
        chk("both_addrok_r", mem_l2cache_addrOK_r, 1'b1);
        l2cache_mem_req_r = 1'b0;
        @(negedge clk);
        ar_phase(32'h0000_1000, 8'd7, 3'd2);
        for (int i = 0; i < 8; i++) r_beat(32'h100 + 32'(i), (i == 7), 0);
        chk("both_rd_line", din_mem_l2cache, make_line(32'h100));
        release_done();

        // Stalled beats and a spurious 9th beat carrying rlast
        read_req(32'h0000_3000, 1'b0, 2'd0);
        ar_phase(32'h0000_3000, 8'd7, 3'd2);
        for (int i = 0; i < 8; i++) r_beat(32'h200 + 32'(i), 1'b0, i % 3);
        chk("ovf_not_done", mem_l2cache_dataOK, 1'b0);
        r_beat(32'hDEAD_BEEF, 1'b1, 2);
        chk("ovf_line", {mem_l2cache_dataOK, din_mem_l2cache}, {1'b1, make_line(32'h200)});
        release_done();

        // Reset during beat 4
        read_req(32'h0000_4000, 1'b0, 2'd0);
        ar_phase(32'h0000_4000, 8'd7, 3'd2);
        for (int i = 0; i < 4; i++) r_beat(32'h400 + 32'(i), 1'b0, 0);
        rdata  = 32'h404;
        rvalid = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_din", din_mem_l2cache, '0);
        chk("rst_mid_ctl", ctl_bus, '0);
        @(negedge clk);
        rvalid = 1'b0;
        rst    = 1'b0;
        seen_ok = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            seen_ok = seen_ok | mem_l2cache_dataOK;
        end
        chk("rst_no_done", seen_ok, 1'b0);
        read_req(32'h0000_5010, 1'b0, 2'd0);
        ar_phase(32'h0000_5000, 8'd7, 3'd2);
        for (int i = 0; i < 8; i++) r_beat(32'h500 + 32'(i), (i == 7), 0);
        exp_line = make_line(32'h500);
        chk("post_rst_line", {mem_l2cache_dataOK, din_mem_l2cache}, {1'b1, exp_line});
        release_done();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
